// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache main-memory arbiter.
// Tags identify which cache owns the outstanding memory transaction.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    localparam int TAG_IC = 0;
    localparam int TAG_DC = 1;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_BEATS  = 4;
    localparam int DEF_TAG_W  = 4;

    function automatic int tag_of(input owner_e o);
        return (o == OWN_DC) ? TAG_DC : TAG_IC;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. Remembers the last winner so that under
// contention the other side goes next; reset favours dcache first.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,    // bit 0 icache, bit 1 dcache
    output logic [1:0] grant,
    output owner_e     winner
);

    owner_e last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == OWN_IC) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
        winner = grant[1] ? OWN_DC : OWN_IC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= OWN_IC;
        end else if (|grant) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache refills and dcache refill/writeback.
// One line transaction at a time: arbitrate, issue command, stream write beats or collect tagged read beats.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEATS  = DEF_BEATS,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,

    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic                dc_wdata_valid,
    output logic                dc_wdata_ready,
    input  logic [DATA_W-1:0]   dc_wdata,
    input  logic [DATA_W/8-1:0] dc_wdata_mask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [TAG_W-1:0]    mem_req_tag,
    output logic                mem_wdata_valid,
    input  logic                mem_wdata_ready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wdata_mask,
    input  logic                mem_resp_valid,
    input  logic [TAG_W-1:0]    mem_resp_tag,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                busy
);

    localparam int               CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_e        state, state_next;
    owner_e            owner_q, winner;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [TAG_W-1:0]  tag_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic              wr_beat, rd_beat, last_beat;

    // Arbitration only happens from IDLE; a held reset never grants.
    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     ((state == ST_IDLE) && !reset),
        .req    ({dc_req_valid, ic_req_valid}),
        .grant  (grant),
        .winner (winner)
    );

    assign last_beat      = (beat_cnt == LAST_BEAT);
    assign busy           = (state != ST_IDLE);
    assign mem_req_rw     = rw_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_tag    = tag_q;
    assign mem_wdata      = dc_wdata;
    assign mem_wdata_mask = dc_wdata_mask;

    always_comb begin
        state_next      = state;
        ic_req_ready    = grant[0];
        dc_req_ready    = grant[1];
        mem_req_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        dc_wdata_ready  = 1'b0;
        wr_beat         = 1'b0;
        rd_beat         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) state_next = ST_CMD;
            end
            ST_CMD: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = rw_q ? ST_WDATA : ST_RESP;
            end
            ST_WDATA: begin
                mem_wdata_valid = dc_wdata_valid;
                dc_wdata_ready  = mem_wdata_ready;
                wr_beat         = dc_wdata_valid && mem_wdata_ready;
                if (wr_beat && last_beat) state_next = ST_IDLE;
            end
            ST_RESP: begin
                // Beats tagged for anyone else are silently dropped.
                rd_beat = mem_resp_valid && (mem_resp_tag == tag_q);
                if (rd_beat && last_beat) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner_q  <= OWN_IC;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            tag_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (|grant) begin
                owner_q <= winner;
                tag_q   <= TAG_W'(tag_of(winner));
                addr_q  <= (winner == OWN_DC) ? dc_req_addr : ic_req_addr;
                rw_q    <= (winner == OWN_DC) && dc_req_rw;
            end
            if (state == ST_CMD && mem_req_ready) begin
                beat_cnt <= '0;
            end else if (wr_beat || rd_beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Read beats are registered once toward the owning cache only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_data  <= '0;
        end else begin
            ic_resp_valid <= rd_beat && (owner_q == OWN_IC);
            dc_resp_valid <= rd_beat && (owner_q == OWN_DC);
            if (rd_beat && owner_q == OWN_IC) ic_resp_data <= mem_resp_data;
            if (rd_beat && owner_q == OWN_DC) dc_resp_data <= mem_resp_data;
        end
    end

    resp_one_owner: assert property (@(posedge clk) !(ic_resp_valid && dc_resp_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter; expectations come from a
// transaction-level model (round-robin owner, tag-matched beat counting).
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;
    localparam int TAG_W  = 4;
    localparam int MASK_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic [DATA_W-1:0] ic_resp_data;
    logic              dc_req_valid, dc_req_ready, dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
    logic [DATA_W-1:0] dc_wdata, dc_resp_data;
    logic [MASK_W-1:0] dc_wdata_mask;
    logic              mem_req_valid, mem_req_ready, mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [TAG_W-1:0]  mem_req_tag, mem_resp_tag;
    logic              mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
    logic [DATA_W-1:0] mem_wdata, mem_resp_data;
    logic [MASK_W-1:0] mem_wdata_mask;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Model state: who won the last grant, and which response beat is due next cycle.
    bit                rr_last_dc = 1'b0;
    bit                exp_ic_v = 1'b0, exp_dc_v = 1'b0;
    logic [DATA_W-1:0] exp_ic_d = '0, exp_dc_d = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_wdata_mask(dc_wdata_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_wdata_mask(mem_wdata_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // IDLE cycle: present requests, check the round-robin grant and any leftover read beat.
    task automatic issue(input bit icv, input bit dcv, input bit dcrw,
                         input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                         output bit won_dc);
        bit want_dc;
        @(negedge clk);
        ic_req_valid = icv; ic_req_addr = ia;
        dc_req_valid = dcv; dc_req_rw = dcrw; dc_req_addr = da;
        mem_req_ready = 1'b0; dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        want_dc = (icv && dcv) ? !rr_last_dc : dcv;
        checks++;
        if (ic_req_ready !== (icv && !want_dc) || dc_req_ready !== (dcv && want_dc)) begin
            errors++;
            $display("FAIL grant: ic_ready=%0b dc_ready=%0b, required ic=%0b dc=%0b",
                     ic_req_ready, dc_req_ready, icv && !want_dc, dcv && want_dc);
        end
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: busy=%0b mem_req_valid=%0b, required 0 0", busy, mem_req_valid);
        end
        checks++;
        if (ic_resp_valid !== exp_ic_v || dc_resp_valid !== exp_dc_v ||
            (exp_ic_v && ic_resp_data !== exp_ic_d) || (exp_dc_v && dc_resp_data !== exp_dc_d)) begin
            errors++;
            $display("FAIL last_beat: ic_v=%0b dc_v=%0b ic_d=%h dc_d=%h, required ic_v=%0b dc_v=%0b ic_d=%h dc_d=%h",
                     ic_resp_valid, dc_resp_valid, ic_resp_data, dc_resp_data,
                     exp_ic_v, exp_dc_v, exp_ic_d, exp_dc_d);
        end
        exp_ic_v = 1'b0; exp_dc_v = 1'b0;
        rr_last_dc = want_dc;
        won_dc = want_dc;
    endtask

    // Command phase: stall 'stall' cycles, then accept; fields must hold steady.
    task automatic cmd_phase(input bit owner_dc, input bit rw, input logic [ADDR_W-1:0] addr, input int stall);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            if (owner_dc) begin dc_req_valid = 1'b0; dc_req_addr = ADDR_W'($urandom); end
            else          begin ic_req_valid = 1'b0; ic_req_addr = ADDR_W'($urandom); end
            mem_req_ready = (i == stall);
            #1;
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_rw !== rw || mem_req_addr !== addr ||
                mem_req_tag !== TAG_W'(owner_dc)) begin
                errors++;
                $display("FAIL cmd: valid=%0b rw=%0b addr=%h tag=%0d, required 1 %0b %h %0d",
                         mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, rw, addr, owner_dc);
            end
            checks++;
            if (ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0 || busy !== 1'b1 || mem_wdata_valid !== 1'b0 ||
                ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL cmd_side: rdy=%0b%0b busy=%0b wv=%0b resp=%0b%0b, required 00 1 0 00",
                         ic_req_ready, dc_req_ready, busy, mem_wdata_valid, ic_resp_valid, dc_resp_valid);
            end
        end
    endtask

    // Write phase: random handshake on both sides; exactly BEATS transfers end the line.
    task automatic wdata_phase(input bit tail_check);
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
        int sent = 0;
        int cyc = 0;
        d = rnd_data(); m = MASK_W'($urandom);
        while (sent < BEATS && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_req_ready = 1'b0;
            dc_wdata_valid = ($urandom_range(0, 3) != 0);
            mem_wdata_ready = ($urandom_range(0, 1) != 0);
            dc_wdata = d; dc_wdata_mask = m;
            #1;
            checks++;
            if (mem_wdata_valid !== dc_wdata_valid || dc_wdata_ready !== mem_wdata_ready ||
                mem_wdata !== d || mem_wdata_mask !== m) begin
                errors++;
                $display("FAIL wdata: wv=%0b wr=%0b d=%h m=%h, required %0b %0b %h %h",
                         mem_wdata_valid, dc_wdata_ready, mem_wdata, mem_wdata_mask,
                         dc_wdata_valid, mem_wdata_ready, d, m);
            end
            checks++;
            if (busy !== 1'b1 || mem_req_valid !== 1'b0 || ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wdata_side: busy=%0b mem_req_valid=%0b resp=%0b%0b, required 1 0 00",
                         busy, mem_req_valid, ic_resp_valid, dc_resp_valid);
            end
            if (dc_wdata_valid && mem_wdata_ready) begin
                sent++;
                d = rnd_data(); m = MASK_W'($urandom);
            end
        end
        if (sent < BEATS) begin
            errors++;
            $display("FAIL wdata_timeout: sent=%0d, required %0d", sent, BEATS);
        end
        if (tail_check) begin
            // A fifth offered beat after completion must not be consumed.
            @(negedge clk);
            dc_wdata_valid = 1'b1; mem_wdata_ready = 1'b1;
            #1;
            checks++;
            if (mem_wdata_valid !== 1'b0 || dc_wdata_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL wdata_tail: wv=%0b wr=%0b busy=%0b, required 0 0 0",
                         mem_wdata_valid, dc_wdata_ready, busy);
            end
        end
    endtask

    // Read phase: random beats, bad_pct percent carrying a foreign tag, until nbeats match.
    task automatic resp_phase(input bit owner_dc, input int nbeats, input int bad_pct);
        int got = 0;
        int cyc = 0;
        bit v, match;
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
        while (got < nbeats && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_req_ready = 1'b0;
            v = ($urandom_range(0, 99) < 70);
            t = TAG_W'(owner_dc);
            if ($urandom_range(0, 99) < bad_pct) t = t ^ TAG_W'($urandom_range(1, 15));
            d = rnd_data();
            mem_resp_valid = v; mem_resp_tag = t; mem_resp_data = d;
            #1;
            checks++;
            if (ic_resp_valid !== exp_ic_v || dc_resp_valid !== exp_dc_v ||
                (exp_ic_v && ic_resp_data !== exp_ic_d) || (exp_dc_v && dc_resp_data !== exp_dc_d)) begin
                errors++;
                $display("FAIL resp: ic_v=%0b dc_v=%0b ic_d=%h dc_d=%h, required ic_v=%0b dc_v=%0b ic_d=%h dc_d=%h",
                         ic_resp_valid, dc_resp_valid, ic_resp_data, dc_resp_data,
                         exp_ic_v, exp_dc_v, exp_ic_d, exp_dc_d);
            end
            checks++;
            if (busy !== 1'b1 || mem_req_valid !== 1'b0 || ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL resp_side: busy=%0b mem_req_valid=%0b rdy=%0b%0b, required 1 0 00",
                         busy, mem_req_valid, ic_req_ready, dc_req_ready);
            end
            match = v && (t == TAG_W'(owner_dc));
            exp_ic_v = match && !owner_dc;
            exp_dc_v = match && owner_dc;
            if (match) begin
                if (owner_dc) exp_dc_d = d; else exp_ic_d = d;
                got++;
            end
        end
        if (got < nbeats) begin
            errors++;
            $display("FAIL resp_timeout: beats=%0d, required %0d", got, nbeats);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_req_ready = 1'b0;
        dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0 ||
            ic_resp_valid !== exp_ic_v || dc_resp_valid !== exp_dc_v ||
            (exp_ic_v && ic_resp_data !== exp_ic_d) || (exp_dc_v && dc_resp_data !== exp_dc_d)) begin
            errors++;
            $display("FAIL idle: busy=%0b mrv=%0b rdy=%0b%0b resp=%0b%0b, required 0 0 00 %0b%0b",
                     busy, mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
                     exp_ic_v, exp_dc_v);
        end
        exp_ic_v = 1'b0; exp_dc_v = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ic_req_valid = 1'b1; dc_req_valid = 1'b1; dc_req_rw = 1'b0;
        ic_req_addr = '0; dc_req_addr = '0;
        mem_req_ready = 1'b0; dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0;
        dc_wdata = '0; dc_wdata_mask = '0; mem_resp_tag = '0; mem_resp_data = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: ic=%0b dc=%0b, required 0 0", ic_req_ready, dc_req_ready);
            end
        end
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_wdata_valid !== 1'b0 || dc_wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%0b mrv=%0b wv=%0b wr=%0b, required 0 0 0 0",
                     busy, mem_req_valid, mem_wdata_valid, dc_wdata_ready);
        end
        checks++;
        if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0 || ic_resp_data !== '0 || dc_resp_data !== '0) begin
            errors++;
            $display("FAIL reset_resp: v=%0b%0b ic_d=%h dc_d=%h, required 00 0 0",
                     ic_resp_valid, dc_resp_valid, ic_resp_data, dc_resp_data);
        end
        reset = 1'b0; ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        rr_last_dc = 1'b0; exp_ic_v = 1'b0; exp_dc_v = 1'b0;
    endtask

    task automatic test_contention();
        bit w;
        logic [ADDR_W-1:0] ia = 28'h0000040, da = 28'h0000300;
        issue(1, 1, 0, ia, da, w);
        cmd_phase(w, 0, w ? da : ia, 1);
        resp_phase(w, BEATS, 20);
        issue(1, 0, 0, ia, da, w);
        cmd_phase(w, 0, ia, 0);
        resp_phase(w, BEATS, 0);
        ia = 28'h0000080; da = 28'h0000340;
        issue(1, 1, 1, ia, da, w);
        cmd_phase(w, w, w ? da : ia, 2);
        if (w) wdata_phase(0); else resp_phase(w, BEATS, 0);
        issue(1, 0, 0, ia, da, w);
        cmd_phase(w, 0, ia, 0);
        resp_phase(w, BEATS, 0);
        idle_cycle();
    endtask

    task automatic test_ic_read();
        bit w;
        issue(1, 0, 0, 28'h0000010, 28'h0, w);
        cmd_phase(0, 0, 28'h0000010, 0);
        resp_phase(0, BEATS, 0);
        idle_cycle();
    endtask

    task automatic test_dc_write();
        bit w;
        issue(0, 1, 1, 28'h0, 28'h0000200, w);
        cmd_phase(1, 1, 28'h0000200, 3);
        wdata_phase(1);
        idle_cycle();
    endtask

    task automatic test_tag_filter();
        bit w;
        issue(1, 0, 0, 28'h0ABCDE0, 28'h0, w);
        cmd_phase(0, 0, 28'h0ABCDE0, 1);
        resp_phase(0, BEATS, 45);
        issue(0, 1, 0, 28'h0, 28'h0123450, w);
        cmd_phase(1, 0, 28'h0123450, 0);
        resp_phase(1, BEATS, 45);
        idle_cycle();
    endtask

    task automatic test_reset_mid_resp();
        bit w;
        issue(1, 0, 0, 28'h0000500, 28'h0, w);
        cmd_phase(0, 0, 28'h0000500, 0);
        resp_phase(0, 2, 0);
        @(negedge clk);
        reset = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_tag = '0; mem_resp_data = rnd_data();
        #1;
        checks++;
        if (ic_resp_valid !== exp_ic_v || (exp_ic_v && ic_resp_data !== exp_ic_d)) begin
            errors++;
            $display("FAIL pre_reset_beat: v=%0b d=%h, required %0b %h", ic_resp_valid, ic_resp_data, exp_ic_v, exp_ic_d);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b0;
            mem_resp_valid = (i < 2); mem_resp_tag = '0; mem_resp_data = rnd_data();
            #1;
            checks++;
            if (busy !== 1'b0 || mem_req_valid !== 1'b0 || ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset[%0d]: busy=%0b mrv=%0b resp=%0b%0b, required 0 0 00",
                         i, busy, mem_req_valid, ic_resp_valid, dc_resp_valid);
            end
        end
        rr_last_dc = 1'b0; exp_ic_v = 1'b0; exp_dc_v = 1'b0;
        issue(1, 0, 0, 28'h0000600, 28'h0, w);
        cmd_phase(0, 0, 28'h0000600, 1);
        resp_phase(0, BEATS, 10);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        bit w;
        issue(1, 0, 0, 28'h0000700, 28'h0, w);
        cmd_phase(0, 0, 28'h0000700, 0);
        ic_req_valid = 1'b1; ic_req_addr = 28'h0000710;
        resp_phase(0, BEATS, 0);
        issue(1, 0, 0, 28'h0000710, 28'h0, w);
        cmd_phase(0, 0, 28'h0000710, 0);
        resp_phase(0, BEATS, 0);
        idle_cycle();
    endtask

    task automatic test_random();
        bit ic_pend = 1'b0, dc_pend = 1'b0, drw = 1'b0, w;
        logic [ADDR_W-1:0] ia = '0, da = '0;
        int n = 0;
        while ((n < 24 || ic_pend || dc_pend) && n < 60) begin
            if (!ic_pend && $urandom_range(0, 1) == 1) begin ic_pend = 1'b1; ia = ADDR_W'($urandom); end
            if (!dc_pend && ($urandom_range(0, 1) == 1 || !ic_pend) && n < 24) begin
                dc_pend = 1'b1; da = ADDR_W'($urandom); drw = ($urandom_range(0, 1) == 1);
            end
            if (!ic_pend && !dc_pend) begin ic_pend = 1'b1; ia = ADDR_W'($urandom); end
            issue(ic_pend, dc_pend, drw, ia, da, w);
            if (w) dc_pend = 1'b0; else ic_pend = 1'b0;
            cmd_phase(w, w && drw, w ? da : ia, $urandom_range(0, 3));
            if (w && drw) wdata_phase(!ic_pend && !dc_pend);
            else          resp_phase(w, BEATS, 25);
            if (!ic_pend && !dc_pend && $urandom_range(0, 3) == 0) idle_cycle();
            n++;
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_ic_read();
        test_dc_write();
        test_tag_filter();
        test_reset_mid_resp();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
